// File: rtl/uart_boot_loader_if.sv
// rtl/uart_boot_loader_if.sv - byte stream, response and instruction-memory write signals of the boot loader
interface uart_boot_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        imem_wr_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_wr_data;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  tx_data, tx_valid, imem_wr_en, imem_addr, imem_wr_data
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output tx_data, tx_valid, imem_wr_en, imem_addr, imem_wr_data
  );
endinterface

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - loads a framed UART program image into instruction memory and releases the core
module uart_boot_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
  parameter int unsigned MAX_WORDS      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 27000000
) (
  input  logic              clk,
  input  logic              rst,
  uart_boot_loader_if.slave bus,
  output logic              core_hold,
  output logic              done,
  output logic              error
);
  localparam logic [7:0]  SYNC       = 8'hA5;
  localparam logic [7:0]  ACK        = 8'h06;
  localparam logic [7:0]  NAK        = 8'h15;
  localparam logic [31:0] MAX_LEN    = 32'(MAX_WORDS);
  localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, RESP, DONE} state_t;

  state_t      state;
  logic [1:0]  byte_cnt;
  logic [31:0] shift;
  logic [31:0] word_cnt;
  logic [31:0] word_idx;
  logic [31:0] timer;
  logic [7:0]  csum;
  logic [31:0] next_word;
  logic [31:0] idx_next;
  logic        in_frame;
  logic        timed_out;

  // Little-endian assembly: each new byte enters at the top and slides down.
  assign next_word = {bus.rx_data, shift[31:8]};
  assign idx_next  = word_idx + 32'd1;
  assign in_frame  = (state == LEN) || (state == DATA) || (state == CSUM);
  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign timed_out = in_frame && !bus.rx_valid && (timer == TIMER_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      byte_cnt         <= '0;
      shift            <= '0;
      word_cnt         <= '0;
      word_idx         <= '0;
      timer            <= '0;
      csum             <= '0;
      bus.tx_data      <= '0;
      bus.tx_valid     <= 1'b0;
      bus.imem_wr_en   <= 1'b0;
      bus.imem_addr    <= '0;
      bus.imem_wr_data <= '0;
      core_hold        <= 1'b1;
      done             <= 1'b0;
      error            <= 1'b0;
    end else begin
      bus.imem_wr_en <= 1'b0;
      if (in_frame) timer <= bus.rx_valid ? '0 : timer + 32'd1;
      if (timed_out) begin
        error        <= 1'b1;
        bus.tx_data  <= NAK;
        bus.tx_valid <= 1'b1;
        state        <= RESP;
      end else begin
        case (state)
          IDLE: if (bus.rx_valid && bus.rx_data == SYNC) begin
            error    <= 1'b0;
            byte_cnt <= '0;
            word_idx <= '0;
            csum     <= '0;
            timer    <= '0;
            state    <= LEN;
          end
          LEN: if (bus.rx_valid) begin
            shift    <= next_word;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              word_cnt <= next_word;
              if (next_word > MAX_LEN) begin
                error        <= 1'b1;
                bus.tx_data  <= NAK;
                bus.tx_valid <= 1'b1;
                state        <= RESP;
              end else if (next_word == '0) begin
                state <= CSUM;
              end else begin
                state <= DATA;
              end
            end
          end
          DATA: if (bus.rx_valid) begin
            shift    <= next_word;
            csum     <= csum ^ bus.rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              bus.imem_wr_en   <= 1'b1;
              bus.imem_addr    <= BASE_ADDR + {word_idx[29:0], 2'b00};
              bus.imem_wr_data <= next_word;
              word_idx         <= idx_next;
              if (idx_next == word_cnt) state <= CSUM;
            end
          end
          CSUM: if (bus.rx_valid) begin
            if (bus.rx_data == csum) begin
              bus.tx_data <= ACK;
            end else begin
              bus.tx_data <= NAK;
              error       <= 1'b1;
            end
            bus.tx_valid <= 1'b1;
            state        <= RESP;
          end
          RESP: if (bus.tx_valid && bus.tx_ready) begin
            bus.tx_valid <= 1'b0;
            if (bus.tx_data == ACK) begin
              done      <= 1'b1;
              core_hold <= 1'b0;
              state     <= DONE;
            end else begin
              state <= IDLE;
            end
          end
          DONE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
